// File: rtl/conversor_pkg.sv
// Shared definitions for the BCD scan converter: FSM states, digit limit and
// the elaboration-time digit-count helper.
package conversor_pkg;

    typedef enum logic {
        OCIOSO,
        CONVERTE
    } estado_t;

    localparam int BCD_MAX_DIGITO = 9;

    // Number of decimal digits needed to show 2^largura-1.
    function automatic int ndig_minimo(input int largura);
        longint unsigned maximo;
        longint unsigned limite;
        int n;
        maximo = (64'd1 << largura) - 64'd1;
        n      = 1;
        limite = 10;
        while (limite <= maximo) begin
            n++;
            limite = limite * 10;
        end
        return n;
    endfunction

endpackage

// File: rtl/nucleo_double_dabble.sv
// Iterative shift-add-3 binary to BCD converter, one input bit per clock.
// The result register only changes on the final iteration.
module nucleo_double_dabble
    import conversor_pkg::*;
#(
    parameter int LARGURA = 8,
    parameter int NDIG    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LARGURA-1:0]   valor,
    output logic                 busy,
    output logic                 done,
    output logic [4*NDIG-1:0]    bcd
);
    // state    | meaning
    // OCIOSO   | waiting for start, result held
    // CONVERTE | shifting one bit per cycle, LARGURA cycles

    localparam int CW = $clog2(LARGURA + 1);

    estado_t             estado, estado_prox;
    logic [LARGURA-1:0]  desloc, desloc_prox;
    logic [4*NDIG-1:0]   acc, acc_ajust, acc_prox;
    logic [CW-1:0]       iter;
    logic                ultima;

    always_comb begin
        acc_ajust = acc;
        for (int i = 0; i < NDIG; i++) begin
            if (acc[4*i +: 4] > 4'(BCD_MAX_DIGITO / 2))
                acc_ajust[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        {acc_prox, desloc_prox} = {acc_ajust, desloc} << 1;
    end

    assign ultima = (iter == CW'(LARGURA - 1));
    assign busy   = (estado == CONVERTE);

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:   if (start)  estado_prox = CONVERTE;
            CONVERTE: if (ultima) estado_prox = OCIOSO;
            default:              estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado <= OCIOSO;
            desloc <= '0;
            acc    <= '0;
            iter   <= '0;
            bcd    <= '0;
            done   <= 1'b0;
        end else begin
            estado <= estado_prox;
            done   <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        desloc <= valor;
                        acc    <= '0;
                        iter   <= '0;
                    end
                end
                CONVERTE: begin
                    acc    <= acc_prox;
                    desloc <= desloc_prox;
                    iter   <= iter + 1'b1;
                    if (ultima) begin
                        bcd  <= acc_prox;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/conversor_varredura_bcd.sv
// Binary to BCD converter feeding a shared 7-segment decoder, with a free-running
// digit scan; anodo lags codigoBCD by one cycle to match the registered decoder.
module conversor_varredura_bcd
    import conversor_pkg::*;
#(
    parameter int LARGURA       = 8,
    parameter int NDIG          = 3,
    parameter int DIV_VARREDURA = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LARGURA-1:0]   valor,
    input  logic                 carregar,
    output logic                 ocupado,
    output logic                 pronto,
    output logic [3:0]           codigoBCD,
    output logic [NDIG-1:0]      anodo,
    output logic [4*NDIG-1:0]    digitos
);
    localparam int PW = $clog2(DIV_VARREDURA);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV_VARREDURA - 1);
    localparam logic [IW-1:0] IMAX = IW'(NDIG - 1);

    if (NDIG < ndig_minimo(LARGURA)) begin : g_ndig_invalido
        $error("NDIG too small to represent 2^LARGURA-1");
    end
    if (DIV_VARREDURA < 2) begin : g_div_invalido
        $error("DIV_VARREDURA must be at least 2");
    end

    nucleo_double_dabble #(
        .LARGURA (LARGURA),
        .NDIG    (NDIG)
    ) u_nucleo (
        .clk   (clk),
        .rst_n (rst_n),
        .start (carregar),
        .valor (valor),
        .busy  (ocupado),
        .done  (pronto),
        .bcd   (digitos)
    );

    logic [PW-1:0]   presc;
    logic [IW-1:0]   idx;
    logic [NDIG-1:0] sel;

    // idx names the digit loaded at the next wrap, so the first wrap shows digit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc     <= '0;
            idx       <= '0;
            codigoBCD <= '0;
            sel       <= '1;
            anodo     <= '1;
        end else begin
            anodo <= sel;
            if (presc == PMAX) begin
                presc     <= '0;
                codigoBCD <= digitos[4*idx +: 4];
                sel       <= ~(NDIG'(1) << idx);
                idx       <= (idx == IMAX) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule
